mainfsm: RTL
============

# mainfsm

Multicycle control state machine for the ARM-subset processor. Sequences each instruction through fetch, decode, execute, memory and writeback steps from the instruction's Op/Funct fields. Drives the datapath mux selects and the unconditioned write requests (NextPC, RegW, MemW, Branch) that the conditional-execution logic gates with CondEx. Sits in the decoder, upstream of the condition/flag logic.

## Interface
- No parameters; encodings are fixed in the shared package.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; low forces state to FETCH immediately
- Op  in  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch
- Funct  in  6  instruction bits [25:20]: [5]=I (immediate), [4]=L (branch link), [0]=L/S (load when 1)
- State  out  4  current state encoding (debug/trace)
- IRWrite  out  1  load instruction register
- AdrSrc  out  1  memory address select: 0 PC, 1 ALUOut
- ALUSrcA  out  2  ALU A select
- ALUSrcB  out  2  ALU B select
- ResultSrc  out  2  result mux select
- ALUOp  out  1  1 = ALU decoder uses Funct; 0 = ADD
- NextPC  out  1  PC write request
- RegW  out  1  register write request, pre-CondEx
- MemW  out  1  memory write request, pre-CondEx
- Branch  out  1  branch request, pre-CondEx
- LinkW  out  1  redirect register write to R14

## Operation
- Moore machine: outputs decode from the state register only; unlisted outputs are 0.
- FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUOp=0, ResultSrc=10, IRWrite=1, NextPC=1 -> DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state:
  - Op=01 -> MEMADR
  - Op=00, Funct[5]=0 -> EXECUTER
  - Op=00, Funct[5]=1 -> EXECUTEI
  - Op=10 -> BRANCH (or BRLINK, see Configuration)
  - Op=11 -> UNKNOWN
- MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0; Funct[0]=1 -> MEMRD, else -> MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00 -> MEMWB.
- MEMWB: ResultSrc=01, RegW=1 -> FETCH.
- MEMWR: AdrSrc=1, ResultSrc=00, MemW=1 -> FETCH.
- EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1 -> ALUWB.
- EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1 -> ALUWB.
- ALUWB: ResultSrc=00, RegW=1 -> FETCH.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1 -> FETCH.
- UNKNOWN: all outputs 0 -> FETCH. The instruction is dropped with no architectural write.
- Unencoded state values behave as UNKNOWN.

## Timing
- One state per clock. State register is the only storage.
- Instruction latency in cycles: LDR 5, STR 4, DP reg/imm 4, B 3, undefined 3. BL takes 4 with the macro.
- Op and Funct are sampled only in DECODE and MEMADR. They are taken from the IR, which is stable after FETCH.
- Reset:
  - While reset=0: State=FETCH and outputs equal the FETCH decode.
  - Downstream PC/IR are also held in reset, so IRWrite=1 and NextPC=1 have no effect.
  - The first fetch completes on the first rising edge after deassertion.
- Reset asserted mid-instruction: state returns to FETCH asynchronously and the in-flight instruction is abandoned.
- Write-request outputs (RegW, MemW, Branch, NextPC) are glitch-free per state. CondEx gating happens downstream.

## Configuration
- Macro: MAINFSM_LINK_EN.
- Defined: DECODE with Op=10 and Funct[4]=1 goes to BRLINK, then BRANCH.
  - BRLINK: ResultSrc=11 (incremented PC), RegW=1, LinkW=1.
  - BL therefore takes 4 cycles.
- Undefined: BRLINK does not exist and LinkW is tied to 0. BL executes as B in 3 cycles.

## Structure
- Package mainfsm_pkg holds:
  - 4-bit state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10, BRLINK=11
  - Op constants
  - ALUSrcA, ALUSrcB and ResultSrc code constants
  - a packed control-word typedef
- One sub-module, mainfsm_outdec: purely combinational state -> control word. The top holds the next-state logic and the state register.

## Test plan
- Reset low mid-MEMRD -> State=0 immediately, IRWrite=1, NextPC=1; after release, states 0,1 follow on consecutive edges.
- Op=01, Funct=000001 -> states 0,1,2,3,4,0. RegW=1 only in MEMWB with ResultSrc=01; AdrSrc=1 in MEMRD.
- Op=01, Funct=000000 -> states 0,1,2,5,0. MemW=1 exactly one cycle, in MEMWR.
- Op=00, Funct=100100 -> 0,1,7,8,0 with ALUSrcB=01 and ALUOp=1 in EXECUTEI. Funct=000100 -> 0,1,6,8,0 with ALUSrcB=00.
- Op=10, Funct=010000:
  - With macro: 0,1,11,9,0 with LinkW=RegW=1 in BRLINK, then Branch=1.
  - Without macro: 0,1,9,0 with LinkW never asserted.
- Op=11 -> 0,1,10,0. RegW, MemW and Branch stay 0 throughout.

Source files
------------

// File: rtl/mainfsm_pkg.sv
// rtl/mainfsm_pkg.sv - shared encodings for the multicycle control FSM
//
// Purpose : state encodings, Op field values, datapath mux select codes and
//           the packed control word passed from the output decoder to the top.
// Ports   : none (package).
// Options : MAINFSM_LINK_EN enables the BRLINK state; the encoding is reserved
//           here in both builds so trace values stay stable.

package mainfsm_pkg;

   // State encodings are exported on the State debug port, so the values are
   // fixed and must not be renumbered.
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_UNKNOWN  = 4'd10,
      S_BRLINK   = 4'd11
   } state_e;

   // Instruction bits [27:26].
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_UND = 2'b11;

   // Bit positions inside the 6-bit Funct field (instruction bits [25:20]).
   localparam int FUNCT_I  = 5;
   localparam int FUNCT_BL = 4;
   localparam int FUNCT_LS = 0;

   // ALU A operand select.
   localparam logic [1:0] SRCA_REG = 2'b00;
   localparam logic [1:0] SRCA_PC  = 2'b01;

   // ALU B operand select.
   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result mux select.
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;
   localparam logic [1:0] RES_PCINC  = 2'b11;

   // Everything the datapath sees, decoded from the state alone.
   typedef struct packed {
      logic       irwrite;
      logic       adrsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] resultsrc;
      logic       aluop;
      logic       nextpc;
      logic       regw;
      logic       memw;
      logic       branch;
      logic       linkw;
   } ctrl_t;

endpackage

// File: rtl/mainfsm_outdec.sv
// rtl/mainfsm_outdec.sv - Moore output decoder, state to control word
//
// Purpose : purely combinational map from the current state to the datapath
//           control word. Every field not set for a state stays 0, and any
//           state without an entry (including unencoded values) decodes to
//           all zeros, matching UNKNOWN.
// Ports   : state_i  in  state_e  current state register
//           ctrl_o   out ctrl_t   control word for the datapath
// Options : MAINFSM_LINK_EN adds the BRLINK decode; without it BRLINK falls
//           into the all-zero default and linkw is never set.

module mainfsm_outdec
   import mainfsm_pkg::*;
(
   input  state_e state_i,
   output ctrl_t  ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      unique case (state_i)
         S_FETCH: begin
            ctrl_o.adrsrc    = 1'b0;
            ctrl_o.alusrca   = SRCA_PC;
            ctrl_o.alusrcb   = SRCB_FOUR;
            ctrl_o.aluop     = 1'b0;
            ctrl_o.resultsrc = RES_ALU;
            ctrl_o.irwrite   = 1'b1;
            ctrl_o.nextpc    = 1'b1;
         end
         S_DECODE: begin
            // Precompute PC+8 so a branch target is ready in BRANCH.
            ctrl_o.alusrca   = SRCA_PC;
            ctrl_o.alusrcb   = SRCB_FOUR;
            ctrl_o.resultsrc = RES_ALU;
         end
         S_MEMADR: begin
            ctrl_o.alusrca = SRCA_REG;
            ctrl_o.alusrcb = SRCB_IMM;
            ctrl_o.aluop   = 1'b0;
         end
         S_MEMRD: begin
            ctrl_o.adrsrc    = 1'b1;
            ctrl_o.resultsrc = RES_ALUOUT;
         end
         S_MEMWB: begin
            ctrl_o.resultsrc = RES_DATA;
            ctrl_o.regw      = 1'b1;
         end
         S_MEMWR: begin
            ctrl_o.adrsrc    = 1'b1;
            ctrl_o.resultsrc = RES_ALUOUT;
            ctrl_o.memw      = 1'b1;
         end
         S_EXECUTER: begin
            ctrl_o.alusrca = SRCA_REG;
            ctrl_o.alusrcb = SRCB_REG;
            ctrl_o.aluop   = 1'b1;
         end
         S_EXECUTEI: begin
            ctrl_o.alusrca = SRCA_REG;
            ctrl_o.alusrcb = SRCB_IMM;
            ctrl_o.aluop   = 1'b1;
         end
         S_ALUWB: begin
            ctrl_o.resultsrc = RES_ALUOUT;
            ctrl_o.regw      = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alusrca   = SRCA_REG;
            ctrl_o.alusrcb   = SRCB_IMM;
            ctrl_o.aluop     = 1'b0;
            ctrl_o.resultsrc = RES_ALU;
            ctrl_o.branch    = 1'b1;
         end
`ifdef MAINFSM_LINK_EN
         S_BRLINK: begin
            // Writes the incremented PC into R14 before the branch retires.
            ctrl_o.resultsrc = RES_PCINC;
            ctrl_o.regw      = 1'b1;
            ctrl_o.linkw     = 1'b1;
         end
`endif
         default: begin
            ctrl_o = '0;
         end
      endcase
   end

endmodule

// File: rtl/mainfsm.sv
// rtl/mainfsm.sv - multicycle ARM-subset control FSM (next state + state reg)
//
// Purpose : steps each instruction through fetch/decode/execute/memory/
//           writeback and drives datapath selects plus the write requests
//           that the conditional-execution logic later gates with CondEx.
// Ports   : clk        in   1  rising-edge clock
//           reset      in   1  asynchronous active-low, forces FETCH
//           Op         in   2  instruction [27:26]
//           Funct      in   6  instruction [25:20]
//           State      out  4  current state (trace)
//           IRWrite, AdrSrc, ALUSrcA[2], ALUSrcB[2], ResultSrc[2], ALUOp,
//           NextPC, RegW, MemW, Branch, LinkW  out  datapath controls
// Options : MAINFSM_LINK_EN adds BRLINK so BL writes R14 before branching.

module mainfsm
   import mainfsm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   output logic [3:0] State,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       ALUOp,
   output logic       NextPC,
   output logic       RegW,
   output logic       MemW,
   output logic       Branch,
   output logic       LinkW
);

   state_e state_q;
   state_e state_d;
   ctrl_t  ctrl;

   // Op/Funct come from the IR, which only changes in FETCH, so they are
   // only consulted in DECODE and MEMADR.
   always_comb begin
      state_d = S_FETCH;
      unique case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            unique case (Op)
               OP_MEM: state_d = S_MEMADR;
               OP_DP:  state_d = Funct[FUNCT_I] ? S_EXECUTEI : S_EXECUTER;
`ifdef MAINFSM_LINK_EN
               OP_BR:  state_d = Funct[FUNCT_BL] ? S_BRLINK : S_BRANCH;
`else
               OP_BR:  state_d = S_BRANCH;
`endif
               default: state_d = S_UNKNOWN;
            endcase
         end
         S_MEMADR:   state_d = Funct[FUNCT_LS] ? S_MEMRD : S_MEMWR;
         S_MEMRD:    state_d = S_MEMWB;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
`ifdef MAINFSM_LINK_EN
         S_BRLINK:   state_d = S_BRANCH;
`endif
         // MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN and any unencoded value
         // all retire back to FETCH.
         default:    state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   mainfsm_outdec u_outdec (
      .state_i (state_q),
      .ctrl_o  (ctrl)
   );

   assign State     = state_q;
   assign IRWrite   = ctrl.irwrite;
   assign AdrSrc    = ctrl.adrsrc;
   assign ALUSrcA   = ctrl.alusrca;
   assign ALUSrcB   = ctrl.alusrcb;
   assign ResultSrc = ctrl.resultsrc;
   assign ALUOp     = ctrl.aluop;
   assign NextPC    = ctrl.nextpc;
   assign RegW      = ctrl.regw;
   assign MemW      = ctrl.memw;
   assign Branch    = ctrl.branch;

`ifdef MAINFSM_LINK_EN
   assign LinkW = ctrl.linkw;
   logic unused_funct;
   assign unused_funct = ^Funct[3:1];
`else
   assign LinkW = 1'b0;
   logic unused_bits;
   assign unused_bits = ^{Funct[4:1], ctrl.linkw};
`endif

endmodule
